exibidor_sequencia: RTL

//  Plays the stored colour sequence back to the player before each round. Reads the

---
 rtl/exibidor_sequencia_pkg.sv | 14 +
 rtl/exibidor_sequencia_temporizador.sv | 26 ++
 rtl/exibidor_sequencia.sv | 109 ++++++++++
 3 files changed

// File: rtl/exibidor_sequencia_pkg.sv
// Shared definitions for the sequence playback block: state encoding also used
// by the game FSM and the bench to decode db_estado.
package exibidor_sequencia_pkg;

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

endpackage

// File: rtl/exibidor_sequencia_temporizador.sv
// Display timer: NT-bit up-counter with synchronous clear/enable and a
// terminal-match flag against a run-time limit.
module temporizador_exibicao #(
  parameter int unsigned NT = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          zera,
  input  logic          conta,
  input  logic [NT-1:0] limite,
  output logic          fim
);

  logic [NT-1:0] valor;

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      valor <= '0;
    end else if (conta) begin
      valor <= valor + NT'(1);
    end
  end

  assign fim = (valor == limite);

endmodule

// File: rtl/exibidor_sequencia.sv
// Plays the stored colour sequence back from RAM address 0 up to the captured
// limit, lighting each entry for T_ACESO cycles and blanking for T_APAGADO.
module exibidor_sequencia
  import exibidor_sequencia_pkg::*;
#(
  parameter int unsigned T_ACESO   = 500,
  parameter int unsigned T_APAGADO = 250,
  parameter int unsigned NT        = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] dado_memoria,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       mostra,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam logic [NT-1:0] LIM_ACESO   = NT'(T_ACESO - 1);
  localparam logic [NT-1:0] LIM_APAGADO = NT'(T_APAGADO - 1);

  estado_t       estado, proximo;
  logic [3:0]    limReg;
  logic          zeraTimer, contaTimer, fimTimer;
  logic [NT-1:0] limiteTimer;

  temporizador_exibicao #(
    .NT(NT)
  ) uTemporizador (
    .clock (clock),
    .reset (reset),
    .zera  (zeraTimer),
    .conta (contaTimer),
    .limite(limiteTimer),
    .fim   (fimTimer)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  // Timer is held cleared outside the timed states, so each timed state starts from 0.
  always_comb begin
    proximo     = estado;
    zeraTimer   = 1'b1;
    contaTimer  = 1'b0;
    limiteTimer = '0;
    case (estado)
      OCIOSO:  if (iniciar) proximo = CARREGA;
      CARREGA: proximo = ACESO;
      ACESO: begin
        limiteTimer = LIM_ACESO;
        if (fimTimer) begin
          proximo = APAGADO;
        end else begin
          zeraTimer  = 1'b0;
          contaTimer = 1'b1;
        end
      end
      APAGADO: begin
        limiteTimer = LIM_APAGADO;
        if (fimTimer) begin
          proximo = PROXIMO;
        end else begin
          zeraTimer  = 1'b0;
          contaTimer = 1'b1;
        end
      end
      PROXIMO: proximo = (endereco == limReg) ? FIM : CARREGA;
      FIM:     proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      endereco <= '0;
      leds     <= '0;
      limReg   <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            limReg   <= limite;
            endereco <= '0;
          end
        end
        CARREGA: leds <= dado_memoria;
        PROXIMO: if (endereco != limReg) endereco <= endereco + 4'd1;
        FIM:     leds <= '0;
        default: ;
      endcase
    end
  end

  assign mostra    = (estado == ACESO);
  assign ocupado   = (estado != OCIOSO);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule
